// File: rtl/serial_word_feeder.sv
// Parallel-in, LSB-first serial-out feeder for the bit-serial two's-complement inverter.
// Define SERIAL_FEEDER_WORD_CNT_EN to build the 16-bit completed-word counter.
module serial_word_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             i_out,
    output logic             fr,
    output logic             busy,
    output logic             last,
    output logic [15:0]      word_cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sr, sr_d;
    logic [CW-1:0]    cnt, cnt_d;

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            sr    <= sr_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        sr_d    = sr;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    state_d = SHIFT;
                    sr_d    = din;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                sr_d  = sr >> 1;
                cnt_d = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a pure decode of registers, so the inverter sees clean bits.
    assign din_ready = (state == IDLE);
    assign fr        = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign i_out     = (state == SHIFT) ? sr[0] : 1'b0;
    assign last      = (state == SHIFT) && (cnt == CNT_LAST);

`ifdef SERIAL_FEEDER_WORD_CNT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge t_clk or negedge r) begin
        if (!r)
            word_cnt_q <= '0;
        else if (state == SHIFT && cnt == CNT_LAST)
            word_cnt_q <= word_cnt_q + 16'd1;
    end

    assign word_cnt = word_cnt_q;
`else
    assign word_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: driver pushes expected serial bits, monitor pops on busy.
module tb_serial_word_feeder;
    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready, i_out, fr, busy, last;
    logic [15:0]  word_cnt;

    serial_word_feeder #(.WIDTH(W)) dut (
        .t_clk(t_clk), .r(r), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .i_out(i_out), .fr(fr), .busy(busy),
        .last(last), .word_cnt(word_cnt)
    );

    always #5 t_clk = ~t_clk;

    typedef struct {
        logic         b;
        logic         lst;
        logic [W-1:0] neg;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_words = 0;
    int   busy_left = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_wc();
`ifdef SERIAL_FEEDER_WORD_CNT_EN
        return 16'(exp_words);
`else
        return 16'h0000;
`endif
    endfunction

    // One driver cycle: inputs change at negedge, handshake decided at the following posedge.
    task automatic drive_cycle(input logic v, input logic [W-1:0] d);
        @(negedge t_clk);
        if (busy_left > 0) busy_left--;
        din_valid = v;
        din       = d;
        chk("din_ready", din_ready, busy_left == 0);
        if (v && busy_left == 0) begin
            for (int k = 0; k < W; k++)
                q.push_back('{b: d[k], lst: (k == W - 1), neg: W'(-d)});
            busy_left = W + 1;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge t_clk);
        r = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("rst_i_out", i_out, 0);
        chk("rst_fr", fr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_last", last, 0);
        chk("rst_wcnt", word_cnt, 0);
        q.delete();
        exp_words = 0;
        busy_left = 0;
        repeat (cycles) @(negedge t_clk);
        r = 1'b1;
    endtask

    // Monitor with a behavioural serial inverter downstream to check the chained result.
    initial begin : monitor
        exp_t e;
        logic seen;
        logic [W-1:0] acc;
        int idx;
        seen = 0; acc = '0; idx = 0;
        forever begin
            @(posedge t_clk);
            #1;
            chk("word_cnt", word_cnt, exp_wc());
            if (busy) begin
                chk("fr_busy", fr, 0);
                if (q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("i_out", i_out, e.b);
                    chk("last", last, e.lst);
                    acc[idx] = i_out ^ seen;
                    seen = seen | i_out;
                    idx++;
                    if (e.lst) begin
                        chk("inv_word", acc, e.neg);
                        exp_words++;
                    end
                end
            end else begin
                chk("idle_i_out", i_out, 0);
                chk("idle_fr", fr, 1);
                chk("idle_last", last, 0);
                seen = 0; acc = '0; idx = 0;
            end
        end
    end

    initial begin : driver
        r = 1'b1;
        din = '0;
        din_valid = 1'b0;
        #2;
        do_reset(3);
        repeat (10) drive_cycle(1'b0, '0);

        drive_cycle(1'b1, 8'h0A);
        repeat (W) drive_cycle(1'b0, '0);

        drive_cycle(1'b1, 8'hFF);
        repeat (W) drive_cycle(1'b1, 8'h01);
        drive_cycle(1'b1, 8'h01);
        repeat (W) drive_cycle(1'b0, '0);

        drive_cycle(1'b1, 8'h80);
        drive_cycle(1'b0, '0);
        drive_cycle(1'b1, 8'h55);
        repeat (W - 1) drive_cycle(1'b0, '0);

        drive_cycle(1'b1, 8'hF0);
        repeat (4) drive_cycle(1'b0, '0);
        do_reset(2);
        drive_cycle(1'b1, 8'h03);
        repeat (W) drive_cycle(1'b0, '0);

        drive_cycle(1'b1, 8'h0A);
        drive_cycle(1'b0, '0);
        repeat (W) drive_cycle(1'b1, 8'h01);
        repeat (W) drive_cycle(1'b1, 8'h00);
        repeat (W + 2) drive_cycle(1'b0, '0);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset(1 + $urandom_range(2));
            drive_cycle(($urandom_range(3) != 0), W'($urandom));
        end
        repeat (W + 3) drive_cycle(1'b0, '0);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
